recorder_mc: RTL and testbench

RECORDER_MC -- requirements
Module: recorder_mc

---
 rtl/recorder_mc.sv | 111 +++++++++++
 tb/tb_recorder_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/recorder_mc.sv
// rtl/recorder_mc.sv - multi-channel sample recorder with record, play and loop playback
module recorder_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8192
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        record_in,
  input  logic                        play_in,
  input  logic                        loop_in,
  input  logic                        audio_valid_in,
  input  logic [CHANNELS*WIDTH-1:0]   audio_in,
  output logic [CHANNELS*WIDTH-1:0]   sample_out,
  output logic                        sample_valid_out,
  output logic [1:0]                  state_out,
  output logic [$clog2(DEPTH):0]      length_out,
  output logic                        full_out,
  output logic                        done_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = CHANNELS * WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] addr;
  logic          we;
  logic          last_read;

  // The write pointer is the low bits of the length; it is only used while not full.
  assign full_out  = (length_out == LW'(DEPTH));
  assign addr      = (state_out == S_PLAY) ? rd_ptr : length_out[AW-1:0];
  assign we        = (state_out == S_RECORD) && audio_valid_in && !full_out;
  assign last_read = ({1'b0, rd_ptr} == (length_out - LW'(1)));

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[addr] <= audio_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_out        <= S_IDLE;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      length_out       <= '0;
      done_out         <= 1'b0;
      rd_ptr           <= '0;
    end else begin
      sample_valid_out <= 1'b0;
      done_out         <= 1'b0;
      case (state_out)
        S_IDLE: begin
          if (record_in) begin
            state_out  <= S_RECORD;
            length_out <= '0;
          end else if (play_in && (length_out != '0)) begin
            state_out <= S_PLAY;
            rd_ptr    <= '0;
          end
        end
        S_RECORD: begin
          // Monitor path mirrors every strobe, including ones dropped when full.
          if (audio_valid_in) begin
            sample_out       <= audio_in;
            sample_valid_out <= 1'b1;
            if (!full_out) begin
              length_out <= length_out + LW'(1);
            end
          end
          if (!record_in) begin
            state_out <= S_IDLE;
          end
        end
        S_PLAY: begin
          if (record_in) begin
            state_out  <= S_RECORD;
            length_out <= '0;
            rd_ptr     <= '0;
          end else begin
            if (audio_valid_in) begin
              sample_out       <= mem[addr];
              sample_valid_out <= 1'b1;
              if (last_read) begin
                rd_ptr <= '0;
                if (!loop_in) begin
                  done_out  <= 1'b1;
                  state_out <= S_IDLE;
                end
              end else begin
                rd_ptr <= rd_ptr + AW'(1);
              end
            end
            if (!play_in) begin
              state_out <= S_IDLE;
            end
          end
        end
        default: state_out <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recorder_mc.sv
// tb/tb_recorder_mc.sv - randomized and directed bench for recorder_mc against a queue-based model
module tb_recorder_mc;
  localparam int D  = 16;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          record_in = 1'b0;
  logic          play_in = 1'b0;
  logic          loop_in = 1'b0;
  logic          audio_valid_in = 1'b0;
  logic [DW-1:0] audio_in = '0;
  logic [DW-1:0] sample_out;
  logic          sample_valid_out;
  logic [1:0]    state_out;
  logic [4:0]    length_out;
  logic          full_out;
  logic          done_out;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] m_mem[$];
  int            m_mode = 0;
  int            m_idx = 0;
  logic [DW-1:0] m_sample = '0;
  bit            m_valid = 1'b0;
  bit            m_done = 1'b0;

  recorder_mc #(.WIDTH(8), .CHANNELS(2), .DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .record_in(record_in), .play_in(play_in),
    .loop_in(loop_in), .audio_valid_in(audio_valid_in), .audio_in(audio_in),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out), .state_out(state_out),
    .length_out(length_out), .full_out(full_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mem.delete();
    m_mode = 0; m_idx = 0; m_sample = '0; m_valid = 1'b0; m_done = 1'b0;
  endtask

  // Predicts what the outputs must show after the coming clock edge.
  task automatic model_step(input bit r, input bit p, input bit l, input bit v, input logic [DW-1:0] d);
    m_valid = 1'b0;
    m_done  = 1'b0;
    case (m_mode)
      0: begin
        if (r) begin m_mode = 1; m_mem.delete(); end
        else if (p && m_mem.size() > 0) begin m_mode = 2; m_idx = 0; end
      end
      1: begin
        if (v) begin
          m_sample = d; m_valid = 1'b1;
          if (m_mem.size() < D) m_mem.push_back(d);
        end
        if (!r) m_mode = 0;
      end
      default: begin
        if (r) begin m_mode = 1; m_mem.delete(); end
        else begin
          if (v) begin
            m_sample = m_mem[m_idx]; m_valid = 1'b1;
            m_idx++;
            if (m_idx == m_mem.size()) begin
              m_idx = 0;
              if (!l) begin m_done = 1'b1; m_mode = 0; end
            end
          end
          if (!p) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("sample_out", 32'(sample_out), 32'(m_sample));
    check("sample_valid_out", 32'(sample_valid_out), 32'(m_valid));
    check("state_out", 32'(state_out), 32'(m_mode));
    check("length_out", 32'(length_out), 32'(m_mem.size()));
    check("full_out", 32'(full_out), 32'(m_mem.size() == D));
    check("done_out", 32'(done_out), 32'(m_done));
  endtask

  task automatic cyc(input bit r, input bit p, input bit l, input bit v, input logic [DW-1:0] d);
    record_in = r; play_in = p; loop_in = l; audio_valid_in = v; audio_in = d;
    model_step(r, p, l, v, d);
    @(posedge clk_in); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    compare_all();
  endtask

  logic [DW-1:0] abc [3] = '{16'h0A0A, 16'h0B0B, 16'h0C0C};

  initial begin
    bit r = 1'b0, p = 1'b0, l = 1'b0;
    @(posedge clk_in); #1;
    do_reset();
    check("reset_state", 32'(state_out), 32'd0);
    check("reset_sample", 32'(sample_out), 32'd0);

    // Five samples, played back once with a strobe every seven cycles
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 16'h0100 + 16'(i));
    cyc(0, 0, 0, 0, '0);
    check("t1_length", 32'(length_out), 32'd5);
    cyc(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < 6; g++) cyc(0, 1, 0, 0, '0);
      cyc(0, 1, 0, 1, '0);
      check("t1_sample", 32'(sample_out), 32'h0100 + 32'(i));
      check("t1_done", 32'(done_out), 32'(i == 4));
    end
    check("t1_state_end", 32'(state_out), 32'd0);
    cyc(0, 0, 0, 0, '0);

    // Overfill: twenty strobes into sixteen words
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 1, 16'h0200 + 16'(i));
      if (i == 14) check("t2_full_early", 32'(full_out), 32'd0);
      if (i == 15) check("t2_full_at16", 32'(full_out), 32'd1);
    end
    check("t2_length", 32'(length_out), 32'd16);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 1, '0);
      check("t2_sample", 32'(sample_out), 32'h0200 + 32'(i));
    end
    check("t2_done", 32'(done_out), 32'd1);
    cyc(0, 0, 0, 0, '0);

    // Loop playback of three samples
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, abc[i]);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 1, 0, '0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 1, '0);
      check("t3_sample", 32'(sample_out), 32'(abc[i % 3]));
      check("t3_done", 32'(done_out), 32'd0);
    end
    cyc(0, 0, 0, 0, '0);

    // Empty recording ignores play; record during play suppresses the read
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 16'h1234);
      check("t4_idle", 32'(state_out), 32'd0);
      check("t4_novalid", 32'(sample_valid_out), 32'd0);
    end
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 1, 16'h5555);
    cyc(1, 0, 0, 1, 16'h6666);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    cyc(1, 1, 0, 1, '0);
    check("t4_state_rec", 32'(state_out), 32'd1);
    check("t4_length0", 32'(length_out), 32'd0);
    check("t4_suppressed", 32'(sample_valid_out), 32'd0);
    cyc(0, 0, 0, 0, '0);

    // Reset mid-record clears outputs before the next edge
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 16'h0300 + 16'(i));
    rst_in = 1'b0;
    #1;
    check("t5_sample0", 32'(sample_out), 32'd0);
    check("t5_length0", 32'(length_out), 32'd0);
    check("t5_state0", 32'(state_out), 32'd0);
    model_reset();
    compare_all();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 16'h7777);
      check("t5_play_ignored", 32'(state_out), 32'd0);
    end

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) r = !r;
      if ($urandom_range(0, 9) == 0) p = !p;
      if ($urandom_range(0, 29) == 0) l = !l;
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(r, p, l, $urandom_range(0, 2) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
